// File: rtl/nco_dac_pkg.sv
// Shared types and constants for the NCO-to-DAC SPI output stage.
package nco_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/nco_dac_fmt.sv
// Offset-binary conversion and SPI frame assembly for one NCO sample.
// NCO_DAC_ROUND_EN selects round-to-nearest with saturation; otherwise the code is truncated.
module nco_dac_fmt #(
  parameter int              mpr  = 14,
  parameter int              dacw = 12,
  parameter int              cmdw = 4,
  parameter logic [cmdw-1:0] cmd  = 'h3,
  parameter int              frw  = 16
) (
  input  logic [mpr-1:0] sample,
  output logic [frw-1:0] frame
);

  localparam int SH   = mpr - dacw;
  localparam int PADW = frw - cmdw - dacw;

  logic [mpr-1:0]  off;
  logic [dacw-1:0] code;

  // Flipping the sign bit maps two's complement onto offset binary
  assign off = sample ^ {1'b1, {(mpr-1){1'b0}}};

`ifdef NCO_DAC_ROUND_EN
  generate
    if (SH > 0) begin : g_round
      localparam logic [mpr:0] RND = {{mpr{1'b0}}, 1'b1} << (SH - 1);
      logic [mpr:0] sum;
      logic         unused_sum;
      assign sum        = {1'b0, off} + RND;
      // A carry-out means the rounded value would overflow the code range
      assign code       = sum[mpr] ? {dacw{1'b1}} : sum[mpr-1 -: dacw];
      assign unused_sum = ^sum;
    end else begin : g_noround
      assign code = off;
    end
  endgenerate
`else
  logic unused_off;
  assign code       = off[mpr-1 -: dacw];
  assign unused_off = ^off;
`endif

  assign frame = (frw'(cmd) << (frw - cmdw)) | (frw'(code) << PADW);

endmodule

// File: rtl/nco_dac_spi_tx.sv
// SPI mode-0 transmitter feeding an external serial DAC from the NCO, with a one-deep pending sample.
// Define NCO_DAC_ROUND_EN to round (instead of truncate) the sample to the DAC code width.
module nco_dac_spi_tx
  import nco_dac_pkg::*;
#(
  parameter int              mpr    = 14,
  parameter int              dacw   = 12,
  parameter int              cmdw   = 4,
  parameter logic [cmdw-1:0] cmd    = 'h3,
  parameter int              frw    = 16,
  parameter int              sckdiv = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clken,
  input  logic [mpr-1:0]        fsin_i,
  input  logic                  fsin_valid_i,
  output logic                  dac_cs_n_o,
  output logic                  dac_sclk_o,
  output logic                  dac_sdi_o,
  output logic                  busy_o,
  output logic [DROP_CNT_W-1:0] drop_cnt_o
);

  localparam int BCW = $clog2(frw);
  localparam int CW  = $clog2(2 * sckdiv);

  localparam logic [BCW-1:0] BIT_TOP = BCW'(frw - 1);
  localparam logic [CW-1:0]  DIV_TC  = CW'(sckdiv - 1);
  localparam logic [CW-1:0]  GAP_TC  = CW'(2 * sckdiv - 1);

  state_t                  state, state_nxt;
  logic                    pend_full;
  logic [mpr-1:0]          pend_data;
  logic [frw-2:0]          shifter;
  logic [BCW-1:0]          bit_cnt;
  logic [CW-1:0]           cnt;
  logic                    cs_n, sclk, sdi;
  logic [DROP_CNT_W-1:0]   drop_cnt;

  logic                    accept, direct, load_pend, load, drop;
  logic                    tick, fall, last;
  logic [mpr-1:0]          load_sample;
  logic [frw-1:0]          frame;

  assign accept      = clken && fsin_valid_i;
  assign load        = direct || load_pend;
  assign load_sample = load_pend ? pend_data : fsin_i;
  assign drop        = accept && pend_full && !load_pend;

  nco_dac_fmt #(
    .mpr (mpr),
    .dacw(dacw),
    .cmdw(cmdw),
    .cmd (cmd),
    .frw (frw)
  ) u_fmt (
    .sample(load_sample),
    .frame (frame)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pending sample always wins the load slot; a new sample then refills pending
  always_comb begin
    state_nxt = state;
    direct    = 1'b0;
    load_pend = 1'b0;
    tick      = 1'b0;
    fall      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        load_pend = pend_full;
        direct    = accept && !pend_full;
        if (pend_full || accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        tick = (cnt == DIV_TC);
        fall = tick && sclk;
        last = fall && (bit_cnt == '0);
        if (last) state_nxt = GAP;
      end
      GAP: begin
        if (cnt == GAP_TC) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The frame MSB goes straight to sdi; the shifter holds the remaining bits
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_n    <= 1'b1;
      sclk    <= 1'b0;
      sdi     <= 1'b0;
      shifter <= '0;
      bit_cnt <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shifter <= frame[frw-2:0];
            sdi     <= frame[frw-1];
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            bit_cnt <= BIT_TOP;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
            if (last) begin
              cs_n <= 1'b1;
              sdi  <= 1'b0;
            end else if (fall) begin
              sdi     <= shifter[frw-2];
              shifter <= shifter << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP:     cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept && !direct) begin
        pend_full <= 1'b1;
        pend_data <= fsin_i;
      end else if (load_pend) begin
        pend_full <= 1'b0;
      end
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign dac_cs_n_o = cs_n;
  assign dac_sclk_o = sclk;
  assign dac_sdi_o  = sdi;
  assign busy_o     = (state != IDLE) || pend_full;
  assign drop_cnt_o = drop_cnt;

endmodule

// File: tb/tb_nco_dac_spi_tx.sv
// Self-checking bench for nco_dac_spi_tx: transaction-level model of the pending slot and frame timing.
module tb_nco_dac_spi_tx;

  localparam int FRW     = 16;
  localparam int SCKDIV  = 4;
  localparam int LOW_LEN = 2 * SCKDIV * FRW;
  localparam int PERIOD  = LOW_LEN + 2 * SCKDIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clken = 1'b0;
  logic [13:0] fsin_i = '0;
  logic        fsin_valid_i = 1'b0;
  logic        dac_cs_n_o, dac_sclk_o, dac_sdi_o, busy_o;
  logic [15:0] drop_cnt_o;

  nco_dac_spi_tx dut (
    .clk         (clk),
    .reset       (reset),
    .clken       (clken),
    .fsin_i      (fsin_i),
    .fsin_valid_i(fsin_valid_i),
    .dac_cs_n_o  (dac_cs_n_o),
    .dac_sclk_o  (dac_sclk_o),
    .dac_sdi_o   (dac_sdi_o),
    .busy_o      (busy_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] frame;
    int          start;
  } exp_t;

  typedef struct {
    int bits;
    int nbits;
    int start;
    int stop;
  } rx_t;

  exp_t exp_q[$];
  rx_t  rx_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state: pending slot, drop count, cycle at which the engine can load again
  bit          m_pend = 0;
  logic [13:0] m_samp = '0;
  int          m_drop = 0;
  int          m_free = 0;

  function automatic logic [15:0] exp_frame(input logic [13:0] s);
    int off;
    int code;
    off = int'(s) ^ 8192;
`ifdef NCO_DAC_ROUND_EN
    code = (off + 2) / 4;
    if (code > 4095) code = 4095;
`else
    code = off / 4;
`endif
    return 16'((3 << 12) + code);
  endfunction

  task automatic model_start(input logic [13:0] s);
    exp_t e;
    e.frame = exp_frame(s);
    e.start = cyc + 1;
    exp_q.push_back(e);
    m_free = cyc + PERIOD;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0;
      m_drop = 0;
      m_free = cyc + 1;
      exp_q.delete();
    end else begin
      if (cyc >= m_free && m_pend) begin
        model_start(m_samp);
        m_pend = clken && fsin_valid_i;
        if (m_pend) m_samp = fsin_i;
      end else if (cyc >= m_free && clken && fsin_valid_i) begin
        model_start(fsin_i);
      end else if (clken && fsin_valid_i) begin
        if (m_pend && m_drop < 65535) m_drop++;
        m_pend = 1;
        m_samp = fsin_i;
      end
    end
    cyc++;
  end

  // Bus monitor: captures sdi on each sclk rise while chip select is low
  bit prev_cs_n = 1;
  bit prev_sclk = 0;
  int cap_bits, cap_n, cap_start, rises;

  always @(negedge clk) begin
    if (!dac_cs_n_o) begin
      if (prev_cs_n) begin
        cap_bits  = 0;
        cap_n     = 0;
        cap_start = cyc;
        rises     = 0;
      end
      if (dac_sclk_o && !prev_sclk) begin
        cap_bits = (cap_bits << 1) | int'(dac_sdi_o);
        cap_n++;
        rises++;
      end
    end else if (!prev_cs_n) begin
      rx_q.push_back('{cap_bits, cap_n, cap_start, cyc});
    end
    prev_cs_n = dac_cs_n_o;
    prev_sclk = dac_sclk_o;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [13:0] s, input logic en);
    @(negedge clk);
    fsin_i       = s;
    fsin_valid_i = 1'b1;
    clken        = en;
    @(negedge clk);
    fsin_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!(m_pend == 0 && cyc >= m_free) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_timeout", 32'(k < budget), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_frames(input bit fin);
    exp_t e;
    rx_t  r;
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rx_q.pop_front();
      checkOutput("frame", 32'(r.bits[15:0]), 32'(e.frame));
      checkOutput("nbits", 32'(r.nbits), 32'(FRW));
      checkOutput("cs_fall_cycle", 32'(r.start), 32'(e.start));
      checkOutput("cs_low_len", 32'(r.stop - r.start), 32'(LOW_LEN));
    end
    if (fin) begin
      checkOutput("frames_missing", 32'(exp_q.size()), 32'd0);
      checkOutput("frames_extra", 32'(rx_q.size()), 32'd0);
    end
  endtask

  initial begin
    logic [13:0] dir[8];
    logic [15:0] f;
    int          k;

    dir[0] = 14'h0000;
    dir[1] = 14'h1FFF;
    dir[2] = 14'h2000;
    dir[3] = 14'h0002;
    for (int i = 4; i < 8; i++) dir[i] = 14'($urandom_range(0, 16383));

    repeat (3) @(negedge clk);
    checkOutput("rst_cs_n", 32'(dac_cs_n_o), 32'd1);
    checkOutput("rst_sclk", 32'(dac_sclk_o), 32'd0);
    checkOutput("rst_sdi", 32'(dac_sdi_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt_o), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] directed and random single frames");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(dir[i], 1'b1);
      f = exp_frame(dir[i]);
      checkOutput("cs_n_after_accept", 32'(dac_cs_n_o), 32'd0);
      checkOutput("busy_after_accept", 32'(busy_o), 32'd1);
      checkOutput("sdi_msb", 32'(dac_sdi_o), 32'(f[15]));
      wait_idle(400);
      checkOutput("busy_idle", 32'(busy_o), 32'd0);
      check_frames(1);
    end

    $display("[TB] overwrite of pending sample");
    applyStimulus(14'($urandom_range(0, 16383)), 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(14'h0000, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(14'h2000, 1'b1);
    wait_idle(600);
    checkOutput("drop_after_overwrite", 32'(drop_cnt_o), 32'd1);
    check_frames(1);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 3) != 0));
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    clken = 1'b1;
    wait_idle(1000);
    checkOutput("drop_random", 32'(drop_cnt_o), 32'(m_drop));
    check_frames(1);

    $display("[TB] valid ignored with clken low");
    @(negedge clk);
    clken        = 1'b0;
    fsin_valid_i = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("clken0_busy", 32'(busy_o), 32'd0);
    checkOutput("clken0_cs_n", 32'(dac_cs_n_o), 32'd1);
    fsin_valid_i = 1'b0;
    clken        = 1'b1;
    repeat (5) @(negedge clk);
    check_frames(1);

    $display("[TB] continuous valid, drop counter saturation");
    fsin_valid_i = 1'b1;
    k = 0;
    while (m_drop < 65535 && k < 70000) begin
      @(negedge clk);
      fsin_i = 14'($urandom_range(0, 16383));
      k++;
    end
    checkOutput("sat_timeout", 32'(k < 70000), 32'd1);
    repeat (20) @(negedge clk);
    checkOutput("drop_saturated", 32'(drop_cnt_o), 32'hFFFF);
    fsin_valid_i = 1'b0;
    check_frames(0);

    $display("[TB] reset at 7th sclk rise");
    k = 0;
    while (!(!prev_cs_n && rises == 7) && k < 400) begin
      @(posedge clk);
      k++;
    end
    checkOutput("rise7_timeout", 32'(k < 400), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_cs_n", 32'(dac_cs_n_o), 32'd1);
    checkOutput("abort_sclk", 32'(dac_sclk_o), 32'd0);
    checkOutput("abort_sdi", 32'(dac_sdi_o), 32'd0);
    checkOutput("abort_busy", 32'(busy_o), 32'd0);
    checkOutput("abort_drop", 32'(drop_cnt_o), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rx_q.delete();
    applyStimulus(14'($urandom_range(0, 16383)), 1'b1);
    wait_idle(400);
    checkOutput("drop_after_reset", 32'(drop_cnt_o), 32'd0);
    check_frames(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
